// File: rtl/lcd1602_pkg.sv
// ------------------------------------------------------------------
// lcd1602_pkg : HD44780 command set, sequencer/transfer state types
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package lcd1602_pkg;

   localparam logic [7:0] FUNC_SET   = 8'h38;
   localparam logic [7:0] ENTRY      = 8'h06;
   localparam logic [7:0] CLEAR      = 8'h01;
   localparam logic [7:0] DISP_ON_C  = 8'h0F;
   localparam logic [7:0] DISP_ON_NC = 8'h0C;
   localparam logic [7:0] DDRAM_ROW0 = 8'h80;
   localparam logic [7:0] DDRAM_ROW1 = 8'hC0;

   typedef enum logic [2:0] {
      ST_PWR   = 3'd0,
      ST_INIT  = 3'd1,
      ST_CLRW  = 3'd2,
      ST_ADDR0 = 3'd3,
      ST_ROW0  = 3'd4,
      ST_ADDR1 = 3'd5,
      ST_ROW1  = 3'd6,
      ST_PARK  = 3'd7
   } main_state_t;

   typedef enum logic [1:0] {
      PH_IDLE   = 2'd0,
      PH_SETUP  = 2'd1,
      PH_STROBE = 2'd2,
      PH_HOLD   = 2'd3
   } xfer_phase_t;

   // Init command for position idx of the power-up sequence.
   function automatic logic [7:0] init_cmd(input logic [2:0] idx, input logic [7:0] disp_on);
      logic [7:0] cmd;
      case (idx)
         3'd0, 3'd1, 3'd2: cmd = FUNC_SET;
         3'd3:             cmd = disp_on;
         3'd4:             cmd = ENTRY;
         default:          cmd = CLEAR;
      endcase
      return cmd;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lcd1602_byte_xfer.sv
// ------------------------------------------------------------------
// lcd1602_byte_xfer : one HD44780 bus write as SETUP/STROBE/HOLD ticks
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module lcd1602_byte_xfer
   import lcd1602_pkg::*;
(
   input  logic       clk_48M,
   input  logic       rst,
   input  logic       tick,
   input  logic       start,
   input  logic       rs,
   input  logic [7:0] byte_in,
   output logic       done,
   output logic       lcd_rs,
   output logic       lcd_e,
   output logic [7:0] lcd_data
);

   xfer_phase_t r_phase;
   xfer_phase_t w_phase_n;
   logic        w_load;

   // All phase changes happen on a tick, so every phase is exactly one tick long.
   always_comb begin
      w_phase_n = r_phase;
      w_load    = 1'b0;
      if (tick) begin
         case (r_phase)
            PH_IDLE: begin
               if (start) begin
                  w_phase_n = PH_SETUP;
                  w_load    = 1'b1;
               end
            end
            PH_SETUP:  w_phase_n = PH_STROBE;
            PH_STROBE: w_phase_n = PH_HOLD;
            PH_HOLD: begin
               if (start) begin
                  w_phase_n = PH_SETUP;
                  w_load    = 1'b1;
               end else begin
                  w_phase_n = PH_IDLE;
               end
            end
            default:   w_phase_n = PH_IDLE;
         endcase
      end
   end

   assign done = tick && (r_phase == PH_HOLD);

   always_ff @(posedge clk_48M or negedge rst) begin
      if (!rst) begin
         r_phase  <= PH_IDLE;
         lcd_rs   <= 1'b0;
         lcd_e    <= 1'b0;
         lcd_data <= 8'h00;
      end else begin
         r_phase <= w_phase_n;
         lcd_e   <= (w_phase_n == PH_STROBE);
         if (w_load) begin
            lcd_rs   <= rs;
            lcd_data <= byte_in;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/lcd1602_refresh_ctrl.sv
// ------------------------------------------------------------------
// lcd1602_refresh_ctrl : LCD1602 init + continuous 32-byte frame refresh
// Option LCD_CURSOR_EN: cursor/blink on, cursor parked at last write. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module lcd1602_refresh_ctrl
   import lcd1602_pkg::*;
#(
   parameter int TICK_DIV  = 48000,
   parameter int PWR_TICKS = 20,
   parameter int CLR_TICKS = 2
) (
   input  logic       clk_48M,
   input  logic       rst,
   input  logic       wr_req,
   input  logic       wr_row,
   input  logic [3:0] wr_col,
   input  logic [7:0] wr_char,
   output logic       wr_ack,
   output logic       init_done,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [7:0] lcd_data
);

   localparam int          c_tick_w   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [15:0] c_pwr_last = 16'(PWR_TICKS - 1);
   localparam logic [15:0] c_clr_last = 16'(CLR_TICKS);

   logic [c_tick_w-1:0] r_tick_cnt;
   logic                w_tick;
   logic [7:0]          r_buf [32];
   logic                r_ack;
   logic                w_wr_en;
   main_state_t         r_state;
   main_state_t         w_state_n;
   logic [3:0]          r_idx;
   logic [3:0]          w_idx_n;
   logic [15:0]         r_wait;
   logic [15:0]         w_wait_n;
   logic                r_busy;
   logic                r_init_done;
   logic                w_init_done_n;
   logic                w_start;
   logic                w_rs;
   logic [7:0]          w_byte;
   logic                w_done;
   logic                w_free;
   logic [7:0]          w_disp_on;

   assign w_tick = (r_tick_cnt == c_tick_w'(TICK_DIV - 1));

   always_ff @(posedge clk_48M or negedge rst) begin
      if (!rst)        r_tick_cnt <= '0;
      else if (w_tick) r_tick_cnt <= '0;
      else             r_tick_cnt <= r_tick_cnt + c_tick_w'(1);
   end

   assign w_wr_en = wr_req && !r_ack;
   assign wr_ack  = r_ack;

   always_ff @(posedge clk_48M or negedge rst) begin
      if (!rst) begin
         r_ack <= 1'b0;
         for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
      end else begin
         r_ack <= w_wr_en;
         if (w_wr_en) r_buf[{wr_row, wr_col}] <= wr_char;
      end
   end

`ifdef LCD_CURSOR_EN
   logic       r_cur_row;
   logic [3:0] r_cur_col;

   assign w_disp_on = DISP_ON_C;

   always_ff @(posedge clk_48M or negedge rst) begin
      if (!rst) begin
         r_cur_row <= 1'b0;
         r_cur_col <= 4'd0;
      end else if (w_wr_en) begin
         r_cur_row <= wr_row;
         r_cur_col <= wr_col;
      end
   end
`else
   assign w_disp_on = DISP_ON_NC;
`endif

   // A new byte may be queued on the very tick the previous one completes.
   assign w_free = !r_busy || w_done;

   always_comb begin
      w_state_n     = r_state;
      w_idx_n       = r_idx;
      w_wait_n      = r_wait;
      w_init_done_n = r_init_done;
      w_start       = 1'b0;
      w_rs          = 1'b0;
      w_byte        = 8'h00;
      if (w_tick && w_free) begin
         case (r_state)
            ST_PWR: begin
               if (r_wait == c_pwr_last) begin
                  w_start   = 1'b1;
                  w_byte    = init_cmd(3'd0, w_disp_on);
                  w_idx_n   = 4'd1;
                  w_state_n = ST_INIT;
               end else begin
                  w_wait_n = r_wait + 16'd1;
               end
            end
            ST_INIT: begin
               w_start = 1'b1;
               w_byte  = init_cmd(r_idx[2:0], w_disp_on);
               if (r_idx == 4'd5) begin
                  w_wait_n  = 16'd0;
                  w_state_n = ST_CLRW;
               end else begin
                  w_idx_n = r_idx + 4'd1;
               end
            end
            // Counting starts on the tick the clear byte finishes.
            ST_CLRW: begin
               if (r_wait == c_clr_last) begin
                  w_start       = 1'b1;
                  w_byte        = DDRAM_ROW0;
                  w_idx_n       = 4'd0;
                  w_init_done_n = 1'b1;
                  w_state_n     = ST_ROW0;
               end else begin
                  w_wait_n = r_wait + 16'd1;
               end
            end
            ST_ADDR0: begin
               w_start   = 1'b1;
               w_byte    = DDRAM_ROW0;
               w_idx_n   = 4'd0;
               w_state_n = ST_ROW0;
            end
            ST_ROW0: begin
               w_start = 1'b1;
               w_rs    = 1'b1;
               w_byte  = r_buf[{1'b0, r_idx}];
               w_idx_n = r_idx + 4'd1;
               if (r_idx == 4'd15) w_state_n = ST_ADDR1;
            end
            ST_ADDR1: begin
               w_start   = 1'b1;
               w_byte    = DDRAM_ROW1;
               w_idx_n   = 4'd0;
               w_state_n = ST_ROW1;
            end
            ST_ROW1: begin
               w_start = 1'b1;
               w_rs    = 1'b1;
               w_byte  = r_buf[{1'b1, r_idx}];
               w_idx_n = r_idx + 4'd1;
`ifdef LCD_CURSOR_EN
               if (r_idx == 4'd15) w_state_n = ST_PARK;
`else
               if (r_idx == 4'd15) w_state_n = ST_ADDR0;
`endif
            end
            ST_PARK: begin
`ifdef LCD_CURSOR_EN
               w_start = 1'b1;
               w_byte  = DDRAM_ROW0 | (r_cur_row ? 8'h40 : 8'h00) | {4'h0, r_cur_col};
`endif
               w_state_n = ST_ADDR0;
            end
            default: w_state_n = ST_PWR;
         endcase
      end
   end

   always_ff @(posedge clk_48M or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_PWR;
         r_idx       <= 4'd0;
         r_wait      <= 16'd0;
         r_busy      <= 1'b0;
         r_init_done <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_idx       <= w_idx_n;
         r_wait      <= w_wait_n;
         r_init_done <= w_init_done_n;
         if (w_start)     r_busy <= 1'b1;
         else if (w_done) r_busy <= 1'b0;
      end
   end

   assign init_done = r_init_done;
   assign lcd_rw    = 1'b0;

   lcd1602_byte_xfer u_xfer (
      .clk_48M  (clk_48M),
      .rst      (rst),
      .tick     (w_tick),
      .start    (w_start),
      .rs       (w_rs),
      .byte_in  (w_byte),
      .done     (w_done),
      .lcd_rs   (lcd_rs),
      .lcd_e    (lcd_e),
      .lcd_data (lcd_data)
   );

endmodule

`default_nettype wire
